// File: rtl/boxlambda_reset_ctrl.sv
// ============================================================================
// boxlambda_reset_ctrl : ordered, stretched dm/ndm reset sequencer with sticky reason
// Revision: 1.0
// ============================================================================
`default_nettype none

module boxlambda_reset_ctrl #(
  parameter int STRETCH_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       ext_clk_100,
  input  logic       ext_rst_n,
  input  logic       pll_locked_i,
  input  logic       button_rst_n_i,
  input  logic       ndm_reset_req_i,
  input  logic       sw_reset_req_i,
  input  logic       reason_clr_i,
  output logic       dm_rst_n_o,
  output logic       ndm_rst_n_o,
  output logic [3:0] reset_reason_o
);

  localparam int c_STRETCH_W = $clog2(STRETCH_CYCLES);
  localparam int c_DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_STRETCH_W-1:0] c_STRETCH_LOAD = c_STRETCH_W'(STRETCH_CYCLES - 1);
  localparam logic [c_DEB_W-1:0]     c_DEB_LAST     = c_DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_ASSERT     = 2'd1,
    ST_RELEASE_DM = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  logic [1:0]             r_pll_sync;
  logic [1:0]             r_btn_sync;
  logic                   r_db_level;
  logic                   r_db_fall;
  logic [c_DEB_W-1:0]     r_db_cnt;
  state_t                 r_state;
  logic                   r_full;
  logic [c_STRETCH_W-1:0] r_cnt;

  state_t                 w_state_nxt;
  logic                   w_full_nxt;
  logic [c_STRETCH_W-1:0] w_cnt_nxt;
  logic [3:0]             w_set;
  logic                   w_lock;
  logic                   w_btn;

  assign w_lock = r_pll_sync[1];
  assign w_btn  = r_btn_sync[1];

  // Button syncs reset to 1 so power-up never looks like a press.
  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      r_pll_sync <= 2'b00;
      r_btn_sync <= 2'b11;
      r_db_level <= 1'b1;
      r_db_fall  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_pll_sync <= {r_pll_sync[0], pll_locked_i};
      r_btn_sync <= {r_btn_sync[0], button_rst_n_i};
      r_db_fall  <= (w_btn != r_db_level) && (r_db_cnt == c_DEB_LAST) && !w_btn;
      if (w_btn == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DEB_LAST) begin
        r_db_level <= w_btn;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DEB_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_full_nxt  = r_full;
    w_cnt_nxt   = r_cnt;
    w_set       = 4'b0000;
    if (r_state == ST_WAIT_LOCK) begin
      w_set[1] = r_db_fall;
      if (w_lock) begin
        w_state_nxt = ST_ASSERT;
        w_full_nxt  = 1'b1;
        w_cnt_nxt   = c_STRETCH_LOAD;
      end
    end else begin
      w_set = {sw_reset_req_i, ndm_reset_req_i, r_db_fall, !w_lock};
      if (r_state == ST_ASSERT) begin
        if (r_cnt == '0) w_state_nxt = ST_RELEASE_DM;
        else             w_cnt_nxt   = r_cnt - c_STRETCH_W'(1);
      end else if (r_state == ST_RELEASE_DM) begin
        w_state_nxt = ST_RUN;
      end
      // A full reset already under way is never downgraded to partial.
      if (!w_lock) begin
        w_state_nxt = ST_WAIT_LOCK;
        w_full_nxt  = 1'b1;
      end else if (r_db_fall) begin
        w_state_nxt = ST_ASSERT;
        w_full_nxt  = 1'b1;
        w_cnt_nxt   = c_STRETCH_LOAD;
      end else if (ndm_reset_req_i || sw_reset_req_i) begin
        w_state_nxt = ST_ASSERT;
        w_full_nxt  = (r_state != ST_RUN) && r_full;
        w_cnt_nxt   = c_STRETCH_LOAD;
      end
    end
  end

  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      r_state        <= ST_WAIT_LOCK;
      r_full         <= 1'b1;
      r_cnt          <= '0;
      dm_rst_n_o     <= 1'b0;
      ndm_rst_n_o    <= 1'b0;
      reset_reason_o <= 4'b0001;
    end else begin
      r_state        <= w_state_nxt;
      r_full         <= w_full_nxt;
      r_cnt          <= w_cnt_nxt;
      dm_rst_n_o     <= (w_state_nxt == ST_RELEASE_DM) || (w_state_nxt == ST_RUN) ||
                        ((w_state_nxt == ST_ASSERT) && !w_full_nxt);
      ndm_rst_n_o    <= (w_state_nxt == ST_RUN);
      reset_reason_o <= (reason_clr_i ? 4'b0000 : reset_reason_o) | w_set;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boxlambda_reset_ctrl.sv
// ============================================================================
// tb_boxlambda_reset_ctrl : table-driven bench for boxlambda_reset_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_boxlambda_reset_ctrl;

  localparam int STRETCH = 16;
  localparam int DEB     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic       btn = 1'b1;
  logic       ndm_req = 1'b0;
  logic       sw_req = 1'b0;
  logic       clr = 1'b0;
  logic       dm_rst_n;
  logic       ndm_rst_n;
  logic [3:0] reason;

  always #5 clk = ~clk;

  boxlambda_reset_ctrl #(
    .STRETCH_CYCLES (STRETCH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .ext_clk_100    (clk),
    .ext_rst_n      (rst_n),
    .pll_locked_i   (lock),
    .button_rst_n_i (btn),
    .ndm_reset_req_i(ndm_req),
    .sw_reset_req_i (sw_req),
    .reason_clr_i   (clr),
    .dm_rst_n_o     (dm_rst_n),
    .ndm_rst_n_o    (ndm_rst_n),
    .reset_reason_o (reason)
  );

  typedef struct {
    bit         lock;
    bit         btn;
    bit         ndm;
    bit         sw;
    bit         clr;
    int         cycles;
    bit         dm;
    bit         nd;
    logic [3:0] rsn;
  } vec_t;

  typedef struct {
    bit         dm;
    bit         nd;
    logic [3:0] rsn;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name);
    exp_t e;
    e = sbq.pop_front();
    n_vec++;
    if (dm_rst_n !== e.dm || ndm_rst_n !== e.nd || reason !== e.rsn) begin
      n_miss++;
      $display("FAIL %s: got dm=%0b ndm=%0b reason=%b, want dm=%0b ndm=%0b reason=%b",
               name, dm_rst_n, ndm_rst_n, reason, e.dm, e.nd, e.rsn);
    end
  endtask

  // sw/clr are one-cycle pulses; ndm is held for the whole row.
  task automatic run_vec(input vec_t v, input int idx);
    lock    = v.lock;
    btn     = v.btn;
    ndm_req = v.ndm;
    sw_req  = v.sw;
    clr     = v.clr;
    sbq.push_back('{v.dm, v.nd, v.rsn});
    for (int c = 0; c < v.cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      sw_req = 1'b0;
      clr    = 1'b0;
    end
    check($sformatf("vec%0d", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    //            lock btn ndm sw clr cyc  dm nd reason
    // power-up: dm rises at edge 19, ndm at edge 20
    tbl.push_back('{1, 1, 0, 0, 0, 18, 0, 0, 4'b0001});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 0, 4'b0001});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 1, 4'b0001});
    tbl.push_back('{1, 1, 0, 0, 0,  5, 1, 1, 4'b0001});
    // 3-cycle button glitches are filtered
    tbl.push_back('{1, 0, 0, 0, 0,  3, 1, 1, 4'b0001});
    tbl.push_back('{1, 1, 0, 0, 0,  3, 1, 1, 4'b0001});
    tbl.push_back('{1, 0, 0, 0, 0,  3, 1, 1, 4'b0001});
    tbl.push_back('{1, 1, 0, 0, 0,  3, 1, 1, 4'b0001});
    // stable press: full reset 10 edges after the level changes
    tbl.push_back('{1, 0, 0, 0, 0,  9, 1, 1, 4'b0001});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 1, 1, 4'b0001});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 0, 0, 4'b0011});
    tbl.push_back('{1, 0, 0, 0, 0, 15, 0, 0, 4'b0011});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 1, 0, 4'b0011});
    tbl.push_back('{1, 0, 0, 0, 0,  1, 1, 1, 4'b0011});
    tbl.push_back('{1, 1, 0, 0, 0, 12, 1, 1, 4'b0011});
    // sw pulse together with clear: ndm low for 17 cycles, dm stays high
    tbl.push_back('{1, 1, 0, 1, 1,  1, 1, 0, 4'b1000});
    tbl.push_back('{1, 1, 0, 0, 0, 16, 1, 0, 4'b1000});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 1, 4'b1000});
    tbl.push_back('{1, 1, 0, 0, 1,  1, 1, 1, 4'b0000});
    // ndm request held 40 cycles: ndm low 40+16 cycles
    tbl.push_back('{1, 1, 1, 0, 0, 40, 1, 0, 4'b0100});
    tbl.push_back('{1, 1, 0, 0, 0, 16, 1, 0, 4'b0100});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 1, 4'b0100});
    tbl.push_back('{1, 1, 0, 0, 1,  1, 1, 1, 4'b0000});
    // lock loss during a partial ASSERT, then relock
    tbl.push_back('{1, 1, 0, 1, 0,  1, 1, 0, 4'b1000});
    tbl.push_back('{1, 1, 0, 0, 0,  3, 1, 0, 4'b1000});
    tbl.push_back('{0, 1, 0, 0, 0,  1, 1, 0, 4'b1000});
    tbl.push_back('{0, 1, 0, 0, 0,  1, 1, 0, 4'b1000});
    tbl.push_back('{0, 1, 0, 0, 0,  1, 0, 0, 4'b1001});
    tbl.push_back('{0, 1, 0, 0, 0,  5, 0, 0, 4'b1001});
    tbl.push_back('{1, 1, 0, 0, 0,  2, 0, 0, 4'b1001});
    tbl.push_back('{1, 1, 0, 0, 0, 16, 0, 0, 4'b1001});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 0, 4'b1001});
    tbl.push_back('{1, 1, 0, 0, 0,  1, 1, 1, 4'b1001});
    // into ASSERT again for the async reset sequence below
    tbl.push_back('{1, 1, 0, 1, 0,  1, 1, 0, 4'b1001});
    tbl.push_back('{1, 1, 0, 0, 0,  4, 1, 0, 4'b1001});

    repeat (3) @(negedge clk);
    sbq.push_back('{1'b0, 1'b0, 4'b0001});
    check("reset_state");

    rst_n = 1'b1;
    foreach (tbl[i]) run_vec(tbl[i], i);

    // async reset between clock edges, mid-ASSERT
    #2;
    rst_n = 1'b0;
    #1;
    sbq.push_back('{1'b0, 1'b0, 4'b0001});
    check("async_rst");
    @(negedge clk);
    sbq.push_back('{1'b0, 1'b0, 4'b0001});
    check("rst_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
